// File: rtl/axi_slv_pkg.sv
// Shared constants and FSM state types for the AXI slave memory.
package axi_slv_pkg;

  localparam int unsigned LEN_W  = 4;
  localparam int unsigned ADDR_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_BURST}        r_state_e;

endpackage

// File: rtl/axi_slv_mem_if.sv
// AXI3-style bus bundle between the bandwidth-test master and the slave memory.
interface axi_slv_mem_if #(
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned DATA_WIDTH = 64
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   awid;
  logic [31:0]           awaddr;
  logic [3:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic [3:0]            awregion;
  logic [3:0]            awqos;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_W-1:0]     wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [31:0]           araddr;
  logic [3:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic [3:0]            arregion;
  logic [3:0]            arqos;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awregion, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arregion, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awregion, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arregion, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

endinterface

// File: rtl/bram_dp.sv
// Dual-port RAM: byte-enabled write on port A, read-first registered read on port B.
module bram_dp #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MEM_AW     = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH/8-1:0] a_we,
  input  logic [MEM_AW-1:0]       a_addr,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  input  logic                    b_re,
  input  logic [MEM_AW-1:0]       b_addr,
  output logic [DATA_WIDTH-1:0]   b_rdata
);
  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = 1 << MEM_AW;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (a_we[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
    end
  end

  // Output register holds its value while b_re is low, so a stalled beat stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    b_rdata <= '0;
    else if (b_re) b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/axi_slv_mem.sv
// AXI3-style slave memory: independent write and read burst engines over a dual-port RAM.
module axi_slv_mem
  import axi_slv_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MEM_AW     = 10
) (
  input  logic          s_axi_aclk,
  input  logic          s_axi_aresetn,
  axi_slv_mem_if.slave  s_axi
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);

  // ---------------- write path ----------------
  w_state_e              w_state_q, w_state_d;
  logic [MEM_AW-1:0]     w_idx_q, w_idx_d;
  logic [LEN_W-1:0]      w_cnt_q, w_cnt_d;
  logic [LEN_W-1:0]      w_len_q, w_len_d;
  logic                  w_fixed_q, w_fixed_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [STRB_W-1:0]     ram_we;
  logic                  w_at_len;

  assign w_at_len = (w_cnt_q == w_len_q);

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_cnt_q   <= '0;
      w_len_q   <= '0;
      w_fixed_q <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_cnt_q   <= w_cnt_d;
      w_len_q   <= w_len_d;
      w_fixed_q <= w_fixed_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
    end
  end

  // Burst closes on wlast or on the len-th beat; OKAY only when both agree.
  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_cnt_d   = w_cnt_q;
    w_len_d   = w_len_q;
    w_fixed_d = w_fixed_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    ram_we    = '0;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi.awvalid && awready_q) begin
          w_state_d = W_DATA;
          bid_d     = s_axi.awid;
          w_idx_d   = s_axi.awaddr[MEM_AW+OFF_W-1:OFF_W];
          w_len_d   = s_axi.awlen;
          w_fixed_d = (s_axi.awburst == BURST_FIXED);
          w_cnt_d   = '0;
        end
      end
      W_DATA: begin
        if (s_axi.wvalid && wready_q) begin
          ram_we  = s_axi.wstrb;
          w_cnt_d = LEN_W'(w_cnt_q + 1'b1);
          if (!w_fixed_q) w_idx_d = MEM_AW'(w_idx_q + 1'b1);
          if (s_axi.wlast || w_at_len) begin
            w_state_d = W_RESP;
            bresp_d   = (s_axi.wlast && w_at_len) ? RESP_OKAY : RESP_SLVERR;
          end
        end
      end
      W_RESP: begin
        if (s_axi.bready && bvalid_q) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // ---------------- read path ----------------
  r_state_e              r_state_q, r_state_d;
  logic [MEM_AW-1:0]     r_idx_q, r_idx_d;
  logic [LEN_W-1:0]      r_cnt_q, r_cnt_d;
  logic [LEN_W-1:0]      r_len_q, r_len_d;
  logic                  r_fixed_q, r_fixed_d;
  logic                  r_pend_q, r_pend_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic                  ram_re;
  logic [DATA_WIDTH-1:0] ram_rdata;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_cnt_q   <= '0;
      r_len_q   <= '0;
      r_fixed_q <= 1'b0;
      r_pend_q  <= 1'b0;
      rid_q     <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_cnt_q   <= r_cnt_d;
      r_len_q   <= r_len_d;
      r_fixed_q <= r_fixed_d;
      r_pend_q  <= r_pend_d;
      rid_q     <= rid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
    end
  end

  // r_pend tracks beats still to issue; a RAM read refills the output stage when it frees up.
  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_cnt_d   = r_cnt_q;
    r_len_d   = r_len_q;
    r_fixed_d = r_fixed_q;
    r_pend_d  = r_pend_q;
    rid_d     = rid_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    ram_re    = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi.arvalid && arready_q) begin
          r_state_d = R_BURST;
          rid_d     = s_axi.arid;
          r_idx_d   = s_axi.araddr[MEM_AW+OFF_W-1:OFF_W];
          r_len_d   = s_axi.arlen;
          r_fixed_d = (s_axi.arburst == BURST_FIXED);
          r_cnt_d   = '0;
          r_pend_d  = 1'b1;
        end
      end
      R_BURST: begin
        if (r_pend_q && (!rvalid_q || s_axi.rready)) begin
          ram_re   = 1'b1;
          rvalid_d = 1'b1;
          rlast_d  = (r_cnt_q == r_len_q);
          r_cnt_d  = LEN_W'(r_cnt_q + 1'b1);
          if (!r_fixed_q) r_idx_d = MEM_AW'(r_idx_q + 1'b1);
          if (r_cnt_q == r_len_q) r_pend_d = 1'b0;
        end else if (rvalid_q && s_axi.rready) begin
          rvalid_d = 1'b0;
        end
        if (rvalid_q && s_axi.rready && rlast_q) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  bram_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_AW     (MEM_AW)
  ) u_ram (
    .clk     (s_axi_aclk),
    .rst_n   (s_axi_aresetn),
    .a_we    (ram_we),
    .a_addr  (w_idx_q),
    .a_wdata (s_axi.wdata),
    .b_re    (ram_re),
    .b_addr  (r_idx_q),
    .b_rdata (ram_rdata)
  );

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.bid     = bid_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rlast   = rlast_q;
  assign s_axi.rid     = rid_q;
  assign s_axi.rresp   = RESP_OKAY;
  assign s_axi.rdata   = ram_rdata;

  logic unused_ok;
  assign unused_ok = ^{s_axi.awsize, s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awregion,
                       s_axi.awqos, s_axi.awaddr[31:MEM_AW+OFF_W], s_axi.awaddr[OFF_W-1:0],
                       s_axi.arsize, s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arregion,
                       s_axi.arqos, s_axi.araddr[31:MEM_AW+OFF_W], s_axi.araddr[OFF_W-1:0]};

endmodule

// File: tb/tb_axi_slv_mem.sv
// Self-checking bench for axi_slv_mem against a word-array reference memory.
module tb_axi_slv_mem;
  import axi_slv_pkg::*;

  localparam int unsigned DW    = 64;
  localparam int unsigned IW    = 1;
  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_slv_mem_if #(.ID_WIDTH(IW), .DATA_WIDTH(DW)) bus ();

  axi_slv_mem #(.ID_WIDTH(IW), .DATA_WIDTH(DW), .MEM_AW(AW)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi         (bus)
  );

  logic [63:0] model [DEPTH];
  logic [63:0] wd [16];
  logic [7:0]  ws [16];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a / 8) % DEPTH);
  endfunction

  // Sends min(wl_beat,len)+1 beats; wlast only on beat wl_beat.
  task automatic do_write(input logic [IW-1:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input int wl_beat);
    int idx, nb, cyc;
    nb  = ((wl_beat < len) ? wl_beat : len) + 1;
    idx = widx(addr);
    @(negedge clk);
    bus.awid = id; bus.awaddr = addr; bus.awlen = 4'(len); bus.awburst = burst;
    bus.awsize = 3'd3; bus.awvalid = 1'b1;
    cyc = 0;
    while (!bus.awready && cyc < 64) begin @(negedge clk); cyc++; end
    chk("aw_accept", 64'(cyc < 64), 64'd1);
    @(negedge clk);
    bus.awvalid = 1'b0;
    chk("wready_after_aw", 64'(bus.wready), 64'd1);
    for (int b = 0; b < nb; b++) begin
      bus.wvalid = 1'b1; bus.wdata = wd[b]; bus.wstrb = ws[b]; bus.wlast = (b == wl_beat);
      cyc = 0;
      while (!bus.wready && cyc < 64) begin @(negedge clk); cyc++; end
      chk("w_accept", 64'(cyc < 64), 64'd1);
      for (int by = 0; by < 8; by++)
        if (ws[b][by]) model[idx][by*8 +: 8] = wd[b][by*8 +: 8];
      if (burst != BURST_FIXED) idx = (idx + 1) % DEPTH;
      @(negedge clk);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
    chk("bvalid_next_cycle", 64'(bus.bvalid), 64'd1);
    chk("wready_end", 64'(bus.wready), 64'd0);
    cyc = 0;
    while (!bus.bvalid && cyc < 64) begin @(negedge clk); cyc++; end
    chk("bresp", 64'(bus.bresp), (wl_beat == len) ? 64'(RESP_OKAY) : 64'(RESP_SLVERR));
    chk("bid", 64'(bus.bid), 64'(id));
    @(negedge clk);
    bus.bready = 1'b0;
    chk("bvalid_drop", 64'(bus.bvalid), 64'd0);
  endtask

  // rmode: 0 rready always high, 1 pattern 1,0,0 repeating, 2 random.
  task automatic do_read(input logic [IW-1:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input int rmode, output logic [63:0] last_data);
    logic [63:0] exp [16];
    logic [63:0] prev;
    int idx, ncyc, beats, first, lastc, k, cyc;
    logic rr, stalled;
    idx = widx(addr);
    for (int b = 0; b <= len; b++) begin
      exp[b] = model[idx];
      if (burst != BURST_FIXED) idx = (idx + 1) % DEPTH;
    end
    @(negedge clk);
    bus.arid = id; bus.araddr = addr; bus.arlen = 4'(len); bus.arburst = burst;
    bus.arsize = 3'd3; bus.arvalid = 1'b1;
    cyc = 0;
    while (!bus.arready && cyc < 64) begin @(negedge clk); cyc++; end
    chk("ar_accept", 64'(cyc < 64), 64'd1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    ncyc = 1; beats = 0; first = -1; lastc = -1; k = 0; stalled = 1'b0; prev = '0;
    last_data = '0;
    while (beats <= len && ncyc < 300) begin
      if (rmode == 0)      rr = 1'b1;
      else if (rmode == 1) rr = ((k % 3) == 0);
      else                 rr = 1'($urandom_range(0, 1));
      bus.rready = rr;
      if (bus.rvalid) begin
        if (first < 0) first = ncyc;
        if (stalled) chk("rdata_stable", bus.rdata, prev);
        chk("rdata", bus.rdata, exp[beats]);
        chk("rlast", 64'(bus.rlast), 64'(beats == len));
        chk("rid", 64'(bus.rid), 64'(id));
        chk("rresp", 64'(bus.rresp), 64'(RESP_OKAY));
        stalled = !rr;
        prev = bus.rdata;
        if (rr) begin beats++; lastc = ncyc; last_data = bus.rdata; end
        k++;
      end
      @(negedge clk);
      ncyc++;
    end
    bus.rready = 1'b0;
    chk("r_beat_count", 64'(beats), 64'(len + 1));
    chk("r_first_valid", 64'(first), 64'd2);
    if (rmode == 0) chk("r_last_cycle", 64'(lastc), 64'(2 + len));
    chk("rvalid_drop", 64'(bus.rvalid), 64'd0);
    chk("arready_back", 64'(bus.arready), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] got;
    logic [31:0] a;
    int len, wl, rm;
    logic [1:0] bt;

    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awlock = '0; bus.awcache = '0; bus.awprot = '0; bus.awregion = '0; bus.awqos = '0;
    bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arregion = '0; bus.arqos = '0;
    bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_awready", 64'(bus.awready), 64'd0);
    chk("rst_wready",  64'(bus.wready),  64'd0);
    chk("rst_bvalid",  64'(bus.bvalid),  64'd0);
    chk("rst_bresp",   64'(bus.bresp),   64'd0);
    chk("rst_bid",     64'(bus.bid),     64'd0);
    chk("rst_arready", 64'(bus.arready), 64'd0);
    chk("rst_rvalid",  64'(bus.rvalid),  64'd0);
    chk("rst_rlast",   64'(bus.rlast),   64'd0);
    chk("rst_rresp",   64'(bus.rresp),   64'd0);
    chk("rst_rid",     64'(bus.rid),     64'd0);
    chk("rst_rdata",   bus.rdata,        64'd0);
    rst_n = 1'b1;
    chk("awready_at_release", 64'(bus.awready), 64'd0);
    @(negedge clk);
    chk("awready_1cyc", 64'(bus.awready), 64'd1);
    chk("arready_1cyc", 64'(bus.arready), 64'd1);

    // Fill the whole RAM so every later read has a known reference
    for (int blk = 0; blk < 64; blk++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
      do_write(1'b0, 32'(blk * 128), 15, BURST_INCR, 15);
    end

    // INCR write then read
    for (int i = 0; i < 16; i++) begin wd[i] = 64'(i); ws[i] = 8'hFF; end
    do_write(1'b0, 32'h100, 15, BURST_INCR, 15);
    do_read(1'b0, 32'h100, 15, BURST_INCR, 0, got);
    chk("incr_last_beat", got, 64'd15);

    // Byte strobes
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
    do_write(1'b0, 32'h300, 0, BURST_INCR, 0);
    wd[0] = 64'h1122_3344_5566_7788; ws[0] = 8'h0F;
    do_write(1'b0, 32'h300, 0, BURST_INCR, 0);
    do_read(1'b0, 32'h300, 0, BURST_INCR, 0, got);
    chk("strb_readback", got, 64'hFFFF_FFFF_5566_7788);

    // Backpressure
    do_read(1'b1, 32'h100, 7, BURST_INCR, 1, got);
    chk("bp_last_beat", got, 64'd7);

    // Early wlast gives SLVERR with only beats 0-1 written
    for (int i = 0; i < 16; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    do_write(1'b1, 32'h500, 3, BURST_INCR, 1);
    do_read(1'b0, 32'h500, 3, BURST_INCR, 0, got);
    // Missing wlast: burst closes on beat len anyway
    do_write(1'b0, 32'h580, 2, BURST_INCR, 9);
    do_read(1'b0, 32'h580, 3, BURST_INCR, 2, got);

    // FIXED write keeps only the last beat
    for (int i = 0; i < 4; i++) begin wd[i] = 64'hA5A5_0000_0000_0000 | 64'(i); ws[i] = 8'hFF; end
    do_write(1'b0, 32'h40, 3, BURST_FIXED, 3);
    do_read(1'b0, 32'h40, 0, BURST_INCR, 0, got);
    chk("fixed_word", got, 64'hA5A5_0000_0000_0003);
    do_read(1'b0, 32'h48, 2, BURST_INCR, 0, got);

    // Index wrap from 1023 to 0
    for (int i = 0; i < 4; i++) begin wd[i] = 64'hC0DE_0000_0000_0000 | 64'(i); ws[i] = 8'hFF; end
    do_write(1'b0, 32'(1022 * 8), 3, BURST_INCR, 3);
    do_read(1'b0, 32'(1022 * 8), 3, BURST_INCR, 0, got);
    do_read(1'b0, 32'h0, 1, BURST_INCR, 0, got);
    chk("wrap_word1", got, 64'hC0DE_0000_0000_0003);

    // Concurrent write and read bursts
    for (int i = 0; i < 16; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    fork
      do_write(1'b1, 32'h200, 7, BURST_INCR, 7);
      do_read(1'b1, 32'h100, 15, BURST_INCR, 2, got);
    join

    // Randomised bursts, including aliasing addresses and WRAP encoding
    for (int t = 0; t < 24; t++) begin
      a   = $urandom;
      len = int'($urandom_range(0, 15));
      bt  = 2'($urandom_range(0, 2));
      wl  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : len;
      for (int i = 0; i < 16; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
      do_write(1'($urandom), a, len, bt, wl);
      rm = int'($urandom_range(0, 2));
      do_read(1'($urandom), a, len, bt, rm, got);
    end

    // Reset in the middle of a read burst
    @(negedge clk);
    bus.arid = 1'b1; bus.araddr = 32'h100; bus.arlen = 4'd15; bus.arburst = BURST_INCR;
    bus.arvalid = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_reset_rvalid", 64'(bus.rvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_rvalid_async", 64'(bus.rvalid), 64'd0);
    chk("reset_arready_async", 64'(bus.arready), 64'd0);
    chk("reset_rdata_async", bus.rdata, 64'd0);
    bus.rready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("arready_at_release2", 64'(bus.arready), 64'd0);
    @(negedge clk);
    chk("arready_after_release2", 64'(bus.arready), 64'd1);
    do_read(1'b0, 32'h100, 15, BURST_INCR, 0, got);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
